alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 171 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute stage behind the ALU control unit.
// Holds one operation at a time and keeps each result until it is consumed.
// Optional build macro ALU_EXEC_BARREL_EN: single-cycle barrel shifter for SLL/SRL.
// When the macro is undefined, SLL/SRL use an iterative one-bit-per-cycle shifter.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_SLT = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] op_res;

    assign shamt = op_b[SHW-1:0];

    // Single-cycle result for the request on the inputs; in the iterative build
    // shift codes yield op_a, which is only used for a zero-amount shift.
    always_comb begin
        unique case (alu_select)
            OP_SLT:  op_res = WIDTH'($signed(op_a) < $signed(op_b));
            OP_SUB:  op_res = op_a - op_b;
            OP_AND:  op_res = op_a & op_b;
            OP_OR:   op_res = op_a | op_b;
            OP_XOR:  op_res = op_a ^ op_b;
`ifdef ALU_EXEC_BARREL_EN
            OP_SLL:  op_res = op_a << shamt;
            OP_SRL:  op_res = op_a >> shamt;
`else
            OP_SLL:  op_res = op_a;
            OP_SRL:  op_res = op_a;
`endif
            OP_EQ:   op_res = WIDTH'(op_a == op_b);
            default: op_res = op_a + op_b;
        endcase
    end

`ifndef ALU_EXEC_BARREL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] acc_step;
    logic             is_shift;

    assign is_shift = (alu_select == OP_SLL) || (alu_select == OP_SRL);
    assign acc_step = left_q ? (acc_q << 1) : (acc_q >> 1);

    // Iterative shifter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
        end
    end
`endif

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_EXEC_BARREL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_EXEC_BARREL_EN
                    result_d = op_res;
                    zero_d   = (op_res == '0);
                    state_d  = S_DONE;
`else
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = op_a;
                        cnt_d   = shamt;
                        left_d  = (alu_select == OP_SLL);
                        state_d = S_SHIFT;
                    end else begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_SHIFT: begin
`ifndef ALU_EXEC_BARREL_EN
                acc_d = acc_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    state_d  = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (result, zero, latency, handshake).
module tb_alu_exec_unit;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_select;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        int               lat;
        int               c;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_select (alu_select),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] s, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        int n;
        n = int'(b[4:0]);
        case (s)
            4'd0: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd2: r = a + ~b + 32'd1;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin r = a; for (int i = 0; i < n; i++) r = {r[WIDTH-2:0], 1'b0}; end
            4'd7: begin r = a; for (int i = 0; i < n; i++) r = {1'b0, r[WIDTH-1:1]}; end
            4'd8: r = (a == b) ? 32'd1 : 32'd0;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] s, input logic [WIDTH-1:0] b);
`ifdef ALU_EXEC_BARREL_EN
        return 1;
`else
        if ((s == 4'd6 || s == 4'd7) && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    // Monitor: busy handshake checks and scoreboard pop on each delivered result
    int ov_prev = 0;
    int first_c = 0;
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (q.size() > 0) chk("rdy_busy", 64'(in_ready), 64'd0);
            if (out_valid) begin
                chk("out_expected", 64'(q.size() != 0), 64'd1);
                if (ov_prev == 0) first_c = cyc;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("zero", 64'(zero), 64'(e.z));
                chk("latency", 64'(first_c - e.c), 64'(e.lat));
            end
        end
        ov_prev = out_valid ? 1 : 0;
    end

    // Drive one op, scramble inputs while busy, release after 'hold' stalled DONE cycles
    task automatic run_op(input logic [3:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] expr, input int hold);
        int   c;
        int   dn;
        int   wd;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; alu_select = s; op_a = a; op_b = b;
        out_ready = (hold == 0);
        wd = 0;
        while (!in_ready && wd < 100) begin @(negedge clk); wd++; end
        if (wd >= 100) chk("accept_timeout", 64'd1, 64'd0);
        c = cyc;
        @(posedge clk);
        e.res = expr; e.z = (expr == '0); e.lat = ref_lat(s, b); e.c = c;
        q.push_back(e);
        dn = 0;
        wd = 0;
        while (wd < 200) begin
            @(negedge clk);
            wd++;
            if (out_valid) begin
                if (dn >= hold) out_ready = 1'b1;
                dn++;
            end
            if (out_valid && out_ready) begin
                in_valid = 1'b0;
                break;
            end
            in_valid = 1'($urandom_range(0, 1));
            alu_select = 4'($urandom);
            op_a = $urandom;
            op_b = $urandom;
        end
        if (wd >= 200) chk("done_timeout", 64'd1, 64'd0);
        @(posedge clk);
    endtask

    initial begin
        int c;
        logic [3:0]       s;
        logic [WIDTH-1:0] a, b;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_select = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        rst = 1'b0;

        run_op(4'b0001, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0, 3);
        run_op(4'b0010, 32'd3, 32'd5, 32'hFFFF_FFFE, 0);
        run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        run_op(4'b1000, 32'd7, 32'd7, 32'd1, 1);
        run_op(4'b1000, 32'd7, 32'd8, 32'd0, 0);
        run_op(4'b1111, 32'd2, 32'd3, 32'd5, 0);
        run_op(4'b0110, 32'd1, 32'd31, 32'h8000_0000, 2);
        run_op(4'b0111, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 0);
        run_op(4'b0111, 32'h8000_0000, 32'd4, 32'h0800_0000, 0);
        run_op(4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0);
        run_op(4'b0100, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0);
        run_op(4'b0101, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 0);

`ifndef ALU_EXEC_BARREL_EN
        // Reset during the third SHIFT cycle of SLL n=10 discards the op
        @(negedge clk);
        in_valid = 1'b1; alu_select = 4'b0110; op_a = 32'd3; op_b = 32'd10;
        chk("pre_rst_rdy", 64'(in_ready), 64'd1);
        c = cyc;
        @(posedge clk);
        q.push_back('{32'd3 << 10, 1'b0, 11, c});
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); q.delete();
        @(negedge clk); rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd1);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (15) @(negedge clk);
        chk("midrst_silent", 64'(out_valid), 64'd0);
`endif

        for (int i = 0; i < 24; i++) begin
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) a = b;
            run_op(s, a, b, ref_alu(s, a, b), int'($urandom_range(0, 2)));
        end

        repeat (4) @(negedge clk);
        chk("q_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
